// File: rtl/cache_mem_pkg.sv
// cache_mem_pkg
//   Shared definitions for the cache storage slice: the request opcode and
//   flush sequencer state encodings, default geometry, and small width
//   helpers used to size set/way/byte-enable fields.
package cache_mem_pkg;

   localparam int unsigned DEF_SETS   = 64;
   localparam int unsigned DEF_WAYS   = 2;
   localparam int unsigned DEF_TAG_W  = 22;
   localparam int unsigned DEF_LINE_W = 128;

   // Index width for a power-of-two count; never narrower than one bit.
   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int unsigned be_w(input int unsigned line_w);
      return line_w / 8;
   endfunction

   typedef enum logic [1:0] {
      OP_LOOKUP = 2'd0,
      OP_WRITE  = 2'd1,
      OP_INVAL  = 2'd2,
      OP_RSVD   = 2'd3
   } op_e;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_FLUSH = 1'b1
   } state_e;

endpackage

// File: rtl/cache_plru.sv
// cache_plru
//   Tree pseudo-LRU helper for one set (WAYS-1 bits, node n has children
//   2n+1 / 2n+2; a 0 bit steers the victim search left).  Purely
//   combinational.
// Ports:
//   hit_tree_i  tree of the set addressed by the lookup response
//   wr_tree_i   tree of the set addressed by the incoming WRITE
//   same_set_i  both accesses target the same set this cycle
//   hit_en_i    a lookup hit is being recorded this cycle
//   hit_way_i   way that hit
//   wr_way_i    way being written
//   hit_tree_o  hit_tree_i updated to point away from hit_way_i
//   wr_tree_o   write-set tree updated to point away from wr_way_i
//   victim_o    way selected by hit_tree_i (state before any update)
module cache_plru #(
   parameter int unsigned WAYS = 2
) (
   input  logic [WAYS-2:0]         hit_tree_i,
   input  logic [WAYS-2:0]         wr_tree_i,
   input  logic                    same_set_i,
   input  logic                    hit_en_i,
   input  logic [$clog2(WAYS)-1:0] hit_way_i,
   input  logic [$clog2(WAYS)-1:0] wr_way_i,
   output logic [WAYS-2:0]         hit_tree_o,
   output logic [WAYS-2:0]         wr_tree_o,
   output logic [$clog2(WAYS)-1:0] victim_o
);

   localparam int unsigned WAY_W = $clog2(WAYS);

   // Set every node on the path to way w so it points at the other subtree.
   function automatic logic [WAYS-2:0] touch(input logic [WAYS-2:0] t,
                                             input logic [WAY_W-1:0] w);
      logic [WAYS-2:0] r;
      r = t;
      for (int unsigned l = 0; l < WAY_W; l++) begin
         for (int unsigned o = 0; o < (32'd1 << l); o++) begin
            if ((w >> (WAY_W - l)) == WAY_W'(o)) begin
               r[(32'd1 << l) - 1 + o] = ~w[WAY_W-1-l];
            end
         end
      end
      return r;
   endfunction

   // Walk from the root; the way bits decided so far select the node at
   // the next level.
   function automatic logic [WAY_W-1:0] decode(input logic [WAYS-2:0] t);
      logic [WAY_W-1:0] v;
      v = '0;
      for (int unsigned l = 0; l < WAY_W; l++) begin
         for (int unsigned o = 0; o < (32'd1 << l); o++) begin
            if ((v >> (WAY_W - l)) == WAY_W'(o)) begin
               v[WAY_W-1-l] = t[(32'd1 << l) - 1 + o];
            end
         end
      end
      return v;
   endfunction

   logic [WAYS-2:0] hit_tree;

   assign hit_tree   = touch(hit_tree_i, hit_way_i);
   assign hit_tree_o = hit_tree;
   // A write landing in the set that is recording a hit builds on that hit.
   assign wr_tree_o  = touch((hit_en_i && same_set_i) ? hit_tree : wr_tree_i, wr_way_i);
   assign victim_o   = decode(hit_tree_i);

endmodule

// File: rtl/cache_mem_array.sv
// cache_mem_array
//   N-way set-associative tag/line storage with tag lookup, byte-enable
//   writes, single-line invalidate and a one-set-per-cycle flush sequencer.
//   LOOKUP results (hit, way, line, victim) appear one cycle after accept.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid_i/ready_o   request handshake (ready low while flushing)
//   req_op_i              0 LOOKUP, 1 WRITE, 2 INVAL, 3 no-op
//   req_set_i/way_i       set index / target way (WRITE, INVAL)
//   req_tag_i             tag to compare or store
//   req_line_i/be_i       write data and byte enables
//   resp_valid_o          one-cycle LOOKUP result strobe
//   resp_hit_o/way_o      hit flag and hit way (0 on miss)
//   resp_line_o           hit line (0 on miss)
//   resp_victim_o         refill way for this set
//   flush_i/flush_busy_o  start whole-array invalidate / flush running
// Build option: define CACHE_MEM_PLRU_EN for tree pseudo-LRU victims;
//   otherwise a global round-robin counter is used.
module cache_mem_array
   import cache_mem_pkg::*;
#(
   parameter int unsigned SETS   = DEF_SETS,
   parameter int unsigned WAYS   = DEF_WAYS,
   parameter int unsigned TAG_W  = DEF_TAG_W,
   parameter int unsigned LINE_W = DEF_LINE_W
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    req_valid_i,
   output logic                    req_ready_o,
   input  logic [1:0]              req_op_i,
   input  logic [$clog2(SETS)-1:0] req_set_i,
   input  logic [$clog2(WAYS)-1:0] req_way_i,
   input  logic [TAG_W-1:0]        req_tag_i,
   input  logic [LINE_W-1:0]       req_line_i,
   input  logic [LINE_W/8-1:0]     req_be_i,
   output logic                    resp_valid_o,
   output logic                    resp_hit_o,
   output logic [$clog2(WAYS)-1:0] resp_way_o,
   output logic [LINE_W-1:0]       resp_line_o,
   output logic [$clog2(WAYS)-1:0] resp_victim_o,
   input  logic                    flush_i,
   output logic                    flush_busy_o
);

   localparam int unsigned SET_W = idx_w(SETS);
   localparam int unsigned WAY_W = idx_w(WAYS);
   localparam int unsigned BE_W  = be_w(LINE_W);

   state_e            state_q;
   logic              flush_busy_q;
   logic [SET_W-1:0]  flush_set_q;
   logic [WAYS-1:0]   valid_q [SETS];

   logic [TAG_W-1:0]  tag_mem  [SETS][WAYS];
   logic [LINE_W-1:0] line_mem [SETS][WAYS];
   logic [TAG_W-1:0]  tag_rd_q  [WAYS];
   logic [LINE_W-1:0] line_rd_q [WAYS];
   logic [WAYS-1:0]   valid_rd_q;
   logic [TAG_W-1:0]  tag_q;
   logic              resp_valid_q;
   logic [WAY_W-1:0]  victim_hold_q;

   op_e               req_op;
   logic              ready, acc, acc_lookup, acc_write, acc_inval;
   logic              hit, all_valid;
   logic [WAY_W-1:0]  hit_way, inv_way, policy_way, victim_d;
   logic [LINE_W-1:0] hit_line;

   assign req_op     = op_e'(req_op_i);
   assign ready      = (state_q == ST_IDLE) && !flush_i;
   assign acc        = req_valid_i && ready;
   assign acc_lookup = acc && (req_op == OP_LOOKUP);
   assign acc_write  = acc && (req_op == OP_WRITE);
   assign acc_inval  = acc && (req_op == OP_INVAL);

   // Flush sequencer and valid bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         flush_busy_q <= 1'b0;
         flush_set_q  <= '0;
         for (int unsigned s = 0; s < SETS; s++) begin
            valid_q[s] <= '0;
         end
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (flush_i) begin
                  state_q      <= ST_FLUSH;
                  flush_busy_q <= 1'b1;
                  flush_set_q  <= '0;
               end
            end
            ST_FLUSH: begin
               valid_q[flush_set_q] <= '0;
               flush_set_q          <= flush_set_q + 1'b1;
               if (flush_set_q == SET_W'(SETS - 1)) begin
                  state_q      <= ST_IDLE;
                  flush_busy_q <= 1'b0;
               end
            end
         endcase
         if (acc_write) valid_q[req_set_i][req_way_i] <= 1'b1;
         if (acc_inval) valid_q[req_set_i][req_way_i] <= 1'b0;
      end
   end

   // RAM-style arrays: no reset, registered read of every way of the set.
   always_ff @(posedge clk) begin
      if (acc_write) begin
         tag_mem[req_set_i][req_way_i] <= req_tag_i;
         for (int unsigned b = 0; b < BE_W; b++) begin
            if (req_be_i[b]) begin
               line_mem[req_set_i][req_way_i][8*b +: 8] <= req_line_i[8*b +: 8];
            end
         end
      end
      if (acc_lookup) begin
         for (int unsigned w = 0; w < WAYS; w++) begin
            tag_rd_q[w]  <= tag_mem[req_set_i][w];
            line_rd_q[w] <= line_mem[req_set_i][w];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         resp_valid_q  <= 1'b0;
         valid_rd_q    <= '0;
         tag_q         <= '0;
         victim_hold_q <= '0;
      end else begin
         resp_valid_q <= acc_lookup;
         if (acc_lookup) begin
            valid_rd_q <= valid_q[req_set_i];
            tag_q      <= req_tag_i;
         end
         if (resp_valid_q) victim_hold_q <= victim_d;
      end
   end

   // Scanning from the top way down lets the lowest matching / invalid way win.
   always_comb begin
      hit      = 1'b0;
      hit_way  = '0;
      hit_line = '0;
      inv_way  = '0;
      for (int unsigned i = 0; i < WAYS; i++) begin
         if (valid_rd_q[WAYS-1-i] && (tag_rd_q[WAYS-1-i] == tag_q)) begin
            hit      = 1'b1;
            hit_way  = WAY_W'(WAYS - 1 - i);
            hit_line = line_rd_q[WAYS-1-i];
         end
         if (!valid_rd_q[WAYS-1-i]) inv_way = WAY_W'(WAYS - 1 - i);
      end
      all_valid = &valid_rd_q;
      victim_d  = all_valid ? policy_way : inv_way;
   end

`ifdef CACHE_MEM_PLRU_EN
   logic [WAYS-2:0]  plru_q [SETS];
   logic [SET_W-1:0] resp_set_q;
   logic [WAYS-2:0]  plru_hit_tree, plru_wr_tree;
   logic             hit_upd;

   assign hit_upd = resp_valid_q && hit;

   cache_plru #(.WAYS(WAYS)) u_plru (
      .hit_tree_i (plru_q[resp_set_q]),
      .wr_tree_i  (plru_q[req_set_i]),
      .same_set_i (resp_set_q == req_set_i),
      .hit_en_i   (hit_upd),
      .hit_way_i  (hit_way),
      .wr_way_i   (req_way_i),
      .hit_tree_o (plru_hit_tree),
      .wr_tree_o  (plru_wr_tree),
      .victim_o   (policy_way)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         resp_set_q <= '0;
         for (int unsigned s = 0; s < SETS; s++) begin
            plru_q[s] <= '0;
         end
      end else begin
         if (acc_lookup) resp_set_q <= req_set_i;
         if (hit_upd)    plru_q[resp_set_q] <= plru_hit_tree;
         // Later assignment wins; wr tree already folds in a same-set hit.
         if (acc_write)  plru_q[req_set_i] <= plru_wr_tree;
      end
   end
`else
   logic [WAY_W-1:0] rr_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_q <= '0;
      end else if (resp_valid_q && !hit && all_valid) begin
         rr_q <= rr_q + 1'b1;
      end
   end

   assign policy_way = rr_q;
`endif

   assign req_ready_o   = ready;
   assign resp_valid_o  = resp_valid_q;
   assign resp_hit_o    = hit;
   assign resp_way_o    = hit_way;
   assign resp_line_o   = hit_line;
   // Victim depends on live policy state, so it is frozen between responses.
   assign resp_victim_o = resp_valid_q ? victim_d : victim_hold_q;
   assign flush_busy_o  = flush_busy_q;

endmodule

// File: tb/tb_cache_mem_array.sv
// tb_cache_mem_array
//   Directed bench for cache_mem_array (64 sets, 2 ways).  LOOKUP
//   expectations are queued when issued and compared when the response
//   strobe appears.  Honours CACHE_MEM_PLRU_EN for victim expectations.
module tb_cache_mem_array;

   localparam int unsigned SETS = 64, WAYS = 2, TAG_W = 22, LINE_W = 128;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              req_valid_i = 1'b0;
   logic              req_ready_o;
   logic [1:0]        req_op_i = '0;
   logic [5:0]        req_set_i = '0;
   logic [0:0]        req_way_i = '0;
   logic [TAG_W-1:0]  req_tag_i = '0;
   logic [LINE_W-1:0] req_line_i = '0;
   logic [15:0]       req_be_i = '0;
   logic              resp_valid_o, resp_hit_o;
   logic [0:0]        resp_way_o, resp_victim_o;
   logic [LINE_W-1:0] resp_line_o;
   logic              flush_i = 1'b0;
   logic              flush_busy_o;

   cache_mem_array #(.SETS(SETS), .WAYS(WAYS), .TAG_W(TAG_W), .LINE_W(LINE_W)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req_valid_i   (req_valid_i),
      .req_ready_o   (req_ready_o),
      .req_op_i      (req_op_i),
      .req_set_i     (req_set_i),
      .req_way_i     (req_way_i),
      .req_tag_i     (req_tag_i),
      .req_line_i    (req_line_i),
      .req_be_i      (req_be_i),
      .resp_valid_o  (resp_valid_o),
      .resp_hit_o    (resp_hit_o),
      .resp_way_o    (resp_way_o),
      .resp_line_o   (resp_line_o),
      .resp_victim_o (resp_victim_o),
      .flush_i       (flush_i),
      .flush_busy_o  (flush_busy_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          id;
      logic        hit;
      logic [0:0]  way;
      logic [127:0] line;
      logic [0:0]  victim;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   tests = 0;
   int   fails = 0;
   int   nlook = 0;

   localparam logic [21:0]  T1 = 22'h33_9977;
   localparam logic [127:0] L1 = 128'h1234_5678_ABCD_EF12_1337_4242_4343_6565;
   localparam logic [127:0] L3 = 128'h1234_5678_ABCD_EF12_1337_4242_4343_6500;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic drive(input logic [1:0] op, input int set, input int way,
                        input logic [21:0] tag, input logic [127:0] line, input logic [15:0] be);
      req_op_i    = op;
      req_set_i   = 6'(set);
      req_way_i   = 1'(way);
      req_tag_i   = tag;
      req_line_i  = line;
      req_be_i    = be;
      req_valid_i = 1'b1;
      @(posedge clk);
      #1;
      req_valid_i = 1'b0;
   endtask

   task automatic wr(input int set, input int way, input logic [21:0] tag,
                     input logic [127:0] line, input logic [15:0] be);
      drive(2'd1, set, way, tag, line, be);
   endtask

   task automatic lookup(input int set, input logic [21:0] tag, input logic h,
                         input int way, input logic [127:0] line, input int victim);
      exp_t x;
      x.id     = nlook++;
      x.hit    = h;
      x.way    = 1'(way);
      x.line   = line;
      x.victim = 1'(victim);
      sb.push_back(x);
      drive(2'd0, set, 0, tag, '0, '0);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Response scoreboard.
   always @(negedge clk) begin
      if (rst_n && resp_valid_o) begin
         if (sb.size() == 0) begin
            check("spurious_resp", resp_valid_o, 1'b0);
         end else begin
            e = sb.pop_front();
            check($sformatf("lk%0d_hit", e.id), resp_hit_o, e.hit);
            check($sformatf("lk%0d_way", e.id), resp_way_o, e.way);
            check($sformatf("lk%0d_line", e.id), resp_line_o, e.line);
            check($sformatf("lk%0d_victim", e.id), resp_victim_o, e.victim);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int busy_cnt, rdy_bad;

      // Reset values.
      #12;
      check("rst_ready", req_ready_o, 1'b1);
      check("rst_valid", resp_valid_o, 1'b0);
      check("rst_hit", resp_hit_o, 1'b0);
      check("rst_way", resp_way_o, 1'b0);
      check("rst_line", resp_line_o, '0);
      check("rst_victim", resp_victim_o, 1'b0);
      check("rst_busy", flush_busy_o, 1'b0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(1);

      // Basic write then hit; outputs hold afterwards.
      wr(0, 0, T1, L1, 16'hFFFF);
      lookup(0, T1, 1'b1, 0, L1, 1);
      idle(3);
      check("hold_valid", resp_valid_o, 1'b0);
      check("hold_hit", resp_hit_o, 1'b1);
      check("hold_line", resp_line_o, L1);
      check("hold_victim", resp_victim_o, 1'b1);

      // Misses: empty set, and wrong tag in a half-filled set.
      lookup(1, T1, 1'b0, 0, '0, 0);
      lookup(0, 22'h00_0001, 1'b0, 0, '0, 1);

      // Partial byte write keeps the other bytes.
      wr(0, 0, T1, '0, 16'h0001);
      lookup(0, T1, 1'b1, 0, L3, 1);

      // Invalidate visible to the very next lookup.
      drive(2'd2, 0, 0, T1, '0, '0);
      lookup(0, T1, 1'b0, 0, '0, 0);

      // Duplicate tags: lowest way wins.
      wr(2, 0, 22'h0002AA, {8{16'h1111}}, 16'hFFFF);
      wr(2, 1, 22'h0002AA, {8{16'h2222}}, 16'hFFFF);
      lookup(2, 22'h0002AA, 1'b1, 0, {8{16'h1111}}, 0);

      // Fill sets 0 and 63, then flush with a colliding request.
      wr(0, 0, 22'h000100, 128'hA0, 16'hFFFF);
      wr(0, 1, 22'h000101, 128'hA1, 16'hFFFF);
      wr(63, 0, 22'h000200, 128'hB0, 16'hFFFF);
      wr(63, 1, 22'h000201, 128'hB1, 16'hFFFF);
      lookup(0, 22'h000101, 1'b1, 1, 128'hA1, 0);
      flush_i     = 1'b1;
      req_op_i    = 2'd0;
      req_set_i   = 6'd63;
      req_tag_i   = 22'h000201;
      req_valid_i = 1'b1;
      #1;
      check("flush_blocks_ready", req_ready_o, 1'b0);
      @(posedge clk);
      #1;
      flush_i     = 1'b0;
      req_valid_i = 1'b0;
      check("busy_rise", flush_busy_o, 1'b1);
      busy_cnt = 0;
      rdy_bad  = 0;
      for (int i = 0; i < 200 && flush_busy_o; i++) begin
         busy_cnt++;
         if (req_ready_o) rdy_bad++;
         @(posedge clk);
         #1;
      end
      check("flush_busy_len", busy_cnt, 64);
      check("ready_low_in_flush", rdy_bad, 0);
      check("ready_after_flush", req_ready_o, 1'b1);
      lookup(0, 22'h000100, 1'b0, 0, '0, 0);
      lookup(63, 22'h000201, 1'b0, 0, '0, 0);
      lookup(2, 22'h0002AA, 1'b0, 0, '0, 0);

      // Replacement policy on a full set.
      wr(5, 0, 22'h0000A5, 128'hA5, 16'hFFFF);
      wr(5, 1, 22'h0000B5, 128'hB5, 16'hFFFF);
      lookup(5, 22'h0000A5, 1'b1, 0, 128'hA5, 0);
`ifdef CACHE_MEM_PLRU_EN
      lookup(5, 22'h0000C5, 1'b0, 0, '0, 1);
      lookup(5, 22'h0000C5, 1'b0, 0, '0, 1);
      lookup(5, 22'h0000C5, 1'b0, 0, '0, 1);
`else
      lookup(5, 22'h0000C5, 1'b0, 0, '0, 0);
      lookup(5, 22'h0000C5, 1'b0, 0, '0, 1);
      lookup(5, 22'h0000C5, 1'b0, 0, '0, 0);
`endif
      // Reserved opcode must not write or respond.
      drive(2'd3, 5, 0, 22'h0003FF, '0, 16'hFFFF);
      lookup(5, 22'h0000A5, 1'b1, 0, 128'hA5, 1);
      idle(2);

      // Reset in the middle of a flush.
      flush_i = 1'b1;
      @(posedge clk);
      #1;
      flush_i = 1'b0;
      idle(5);
      check("busy_mid_flush", flush_busy_o, 1'b1);
      rst_n = 1'b0;
      #1;
      check("rst_mid_busy", flush_busy_o, 1'b0);
      check("rst_mid_ready", req_ready_o, 1'b1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      lookup(5, 22'h0000B5, 1'b0, 0, '0, 0);
      idle(3);

      check("sb_drained", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
